// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared state type and default sizing for the FP add sequencer
package fp_add_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ADD_LATENCY_DEF = 3;
  localparam int CNT_W           = $clog2(DATA_W_DEF);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    COMPUTE  = 3'd2,
    WAIT_OUT = 3'd3,
    WRITE    = 3'd4
  } state_t;

endpackage

// File: rtl/fp_add_sequencer_seq_counter.sv
// rtl/fp_add_sequencer_seq_counter.sv - up-counter with sync clear and terminal-count compare
module seq_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - serial load / add / write-out controller for the FP adder datapath
module fp_add_sequencer
  import fp_add_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADD_LATENCY = ADD_LATENCY_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  output logic                      op_shift_en_out,
  output logic                      adder_start_out,
  input  logic                      out_input_rdy_in,
  output logic                      out_wr_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [$clog2(DATA_W)-1:0] bit_cnt_out
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LOAD_TERM = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CALC_TERM = CW'(ADD_LATENCY - 1);

  state_t         state;
  state_t         state_nxt;
  logic           cnt_en;
  logic           cnt_clr;
  logic           at_term;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  term;

  // One counter serves both timed phases; it sits at zero outside them.
  assign cnt_en  = (state == LOAD) || (state == COMPUTE);
  assign cnt_clr = !cnt_en || at_term;
  assign term    = (state == LOAD) ? LOAD_TERM : CALC_TERM;

  seq_counter #(.W(CW)) u_cnt (
    .clk     (clk_in),
    .rst     (rst_in),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .term    (term),
    .cnt     (cnt),
    .at_term (at_term)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_in)         state_nxt = LOAD;
      LOAD:     if (at_term)          state_nxt = COMPUTE;
      COMPUTE:  if (at_term)          state_nxt = WAIT_OUT;
      WAIT_OUT: if (out_input_rdy_in) state_nxt = WRITE;
      WRITE:                          state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign op_shift_en_out = (state == LOAD);
  assign adder_start_out = (state == COMPUTE) && (cnt == '0);
  assign out_wr_out      = (state == WRITE);
  assign done_out        = (state == WRITE);
  assign busy_out        = (state != IDLE);
  assign bit_cnt_out     = (state == LOAD) ? cnt : '0;

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Top-level controller for the serial FP adder datapath: serial operand input registers A/B -> FP adder core -> parallel-in/serial-out output register.
- On a host start request, it:
  - shifts both 32-bit operands in serially, LSB first;
  - launches the adder and waits the fixed adder latency;
  - writes the sum into the output register once that register reports input_rdy.
- Single transaction in flight. No queuing.

Parameters:
- DATA_W, 32: operand/result width; number of LOAD shift cycles.
- ADD_LATENCY, 3: adder cycles from adder_start_out to a valid sum; legal range 1..31.

Ports:
- clk_in  in  1  system clock, rising edge.
- rst_in  in  1  synchronous, active-high reset.
- start_in  in  1  host request; sampled only in IDLE.
- op_shift_en_out  out  1  shift enable to operand registers A and B; high for exactly DATA_W cycles.
- adder_start_out  out  1  one-cycle launch pulse to the FP adder core.
- out_input_rdy_in  in  1  input_rdy of the output register; 1 = can accept a new word.
- out_wr_out  out  1  wr_in of the output register; one-cycle pulse.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse, coincident with out_wr_out.
- bit_cnt_out  out  $clog2(DATA_W)  index of the operand bit being shifted in during LOAD; 0 otherwise.

Behaviour:
- Reset:
  - rst_in is sampled on clk_in; it is the only reset.
  - Reset forces IDLE and clears all counters.
  - All outputs are 0 in the cycle after rst_in is sampled high.
  - Reset mid-operation (any state) aborts immediately. No out_wr_out or done_out is emitted for the aborted transaction.
- Output style: Moore only. Every output is decoded from state/counter flops. No combinational input-to-output path.
- States:
  - IDLE:
    - start_in=1 -> LOAD; counter := 0.
    - Otherwise stay in IDLE.
  - LOAD:
    - op_shift_en_out=1; bit_cnt_out = counter.
    - counter==DATA_W-1 -> COMPUTE with counter := 0; else counter+1.
  - COMPUTE:
    - adder_start_out=1 in the first COMPUTE cycle only (counter==0).
    - counter==ADD_LATENCY-1 -> WAIT_OUT; else counter+1.
  - WAIT_OUT:
    - out_input_rdy_in sampled 1 -> WRITE.
    - Otherwise wait indefinitely. No timeout.
  - WRITE:
    - out_wr_out=1 and done_out=1 for exactly one cycle, then IDLE.
- Cycle timing (start_in sampled at edge 0):
  - op_shift_en_out high for cycles 1..DATA_W.
  - adder_start_out at cycle DATA_W+1.
  - COMPUTE occupies cycles DATA_W+1..DATA_W+ADD_LATENCY.
  - WAIT_OUT at cycle DATA_W+ADD_LATENCY+1.
  - Minimum WRITE cycle is DATA_W+ADD_LATENCY+2 (=37 with defaults).
  - Earliest next accepted start is at the edge after returning to IDLE, i.e. cycle 38.
- Boundary conditions:
  - start_in while busy_out=1 is ignored, not latched.
  - start_in held high continuously yields back-to-back transactions with one IDLE cycle between them.
  - start_in in the same cycle as WRITE is ignored.
  - out_input_rdy_in toggling while in LOAD/COMPUTE is ignored; only its value in WAIT_OUT matters.
  - out_input_rdy_in dropping in the WRITE cycle does not cancel the write (the decision was made in WAIT_OUT).
  - Counter never wraps: the LOAD and COMPUTE terminal counts are exact.
  - ADD_LATENCY=1 gives a single COMPUTE cycle carrying adder_start_out.

Decomposition:
- Package fp_add_pkg holds:
  - state enum: IDLE, LOAD, COMPUTE, WAIT_OUT, WRITE;
  - constants DATA_W_DEF=32 and ADD_LATENCY_DEF=3;
  - CNT_W = $clog2(DATA_W) (ADD_LATENCY <= DATA_W is required).
- One sub-module: seq_counter.
  - Shared up-counter with synchronous clear, enable and a terminal-count compare input.
  - Used for both the LOAD and COMPUTE phases.
- FSM and output decode live in the top module.

Test Plan:
- Reset then idle: rst_in=1 for 2 cycles then 0, start_in=0 for 50 cycles -> all outputs 0; busy_out=0 throughout.
- Nominal, out_input_rdy_in=1, start_in pulsed at cycle 0:
  - op_shift_en_out high exactly cycles 1..32; bit_cnt_out 0..31;
  - adder_start_out at 33 only;
  - out_wr_out=done_out=1 at 37 only; busy_out low from 38.
- Backpressure: out_input_rdy_in=0 until cycle 50, then 1 -> WAIT_OUT holds from 36; out_wr_out at cycle 51 only; no early write.
- Start while busy: extra start_in pulses at cycles 5 and 37 -> ignored; exactly one done_out; the next start at cycle 38 is accepted, giving op_shift_en_out from 39.
- Reset mid-operation: rst_in pulsed at cycle 20 (LOAD) and, in a second run, at cycle 40 in WAIT_OUT -> outputs 0 the following cycle; no out_wr_out/done_out afterwards; a fresh start completes normally.
- Parameter sweep: ADD_LATENCY=1 and ADD_LATENCY=7 with DATA_W=32 -> out_wr_out at cycles 35 and 41 respectively with out_input_rdy_in=1.
